// File: rtl/neuron_layer_sequencer.sv
// Address/strobe sequencer for one fully-connected layer pass: for each output
// neuron, clear the accumulator, stream N input/weight reads, drain, write back.
module neuron_layer_sequencer #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] num_inputs,
    input  logic [ADDR_W-1:0] num_outputs,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [ADDR_W-1:0] weight_base,
    output logic [ADDR_W-1:0] neuro_read_address,
    output logic [ADDR_W-1:0] weight_read_address,
    output logic [ADDR_W-1:0] neuro_write_address,
    output logic              neuro_wr_en,
    output logic              acc_clear,
    output logic              acc_en,
    input  logic              ext_wr_req,
    output logic              ext_wr_grant,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ZERO = '0;

    state_t            state_q;
    logic [ADDR_W-1:0] n_q, m_q, inb_q, outb_q;
    logic [ADDR_W-1:0] i_q, j_q, wp_q;
    logic [ADDR_W-1:0] nrd_q, wrd_q, nwr_q;
    logic              wr_en_q, clr_q, acc_q, busy_q, done_q;

    // Outputs are registered: the address for a MAC cycle is loaded on the
    // edge that enters that cycle, so i_q counts addresses already issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            m_q     <= '0;
            inb_q   <= '0;
            outb_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            wp_q    <= '0;
            nrd_q   <= '0;
            wrd_q   <= '0;
            nwr_q   <= '0;
            wr_en_q <= 1'b0;
            clr_q   <= 1'b0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort && state_q != IDLE) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
            clr_q   <= 1'b0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        n_q    <= num_inputs;
                        m_q    <= num_outputs;
                        inb_q  <= in_base;
                        outb_q <= out_base;
                        wp_q   <= weight_base;
                        i_q    <= '0;
                        j_q    <= '0;
                        busy_q <= 1'b1;
                        if (num_inputs == ZERO || num_outputs == ZERO) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CLEAR;
                            clr_q   <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    clr_q   <= 1'b0;
                    state_q <= MAC;
                    nrd_q   <= inb_q + i_q;
                    wrd_q   <= wp_q;
                    i_q     <= i_q + ONE;
                    wp_q    <= wp_q + ONE;
                end
                MAC: begin
                    // Read data for the address shown now arrives next cycle.
                    acc_q <= 1'b1;
                    if (i_q == n_q) begin
                        state_q <= DRAIN;
                    end else begin
                        nrd_q <= inb_q + i_q;
                        wrd_q <= wp_q;
                        i_q   <= i_q + ONE;
                        wp_q  <= wp_q + ONE;
                    end
                end
                DRAIN: begin
                    acc_q   <= 1'b0;
                    state_q <= WRITE;
                    wr_en_q <= 1'b1;
                    nwr_q   <= outb_q + j_q;
                end
                WRITE: begin
                    wr_en_q <= 1'b0;
                    j_q     <= j_q + ONE;
                    i_q     <= '0;
                    if (j_q == m_q - ONE) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= CLEAR;
                        clr_q   <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    wr_en_q <= 1'b0;
                    clr_q   <= 1'b0;
                    acc_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign neuro_read_address  = nrd_q;
    assign weight_read_address = wrd_q;
    assign neuro_write_address = nwr_q;
    assign neuro_wr_en         = wr_en_q;
    assign acc_clear           = clr_q;
    assign acc_en              = acc_q;
    assign busy                = busy_q;
    assign done                = done_q;
    // Gated by reset so the grant also reads 0 while reset is held.
    assign ext_wr_grant        = ext_wr_req & ~busy_q & reset;

endmodule
